vlsu_sequencer: RTL and testbench

//  Sequences decoded VLE32/VSE32 unit-stride ops into VL single-element SEW-bit accesses on the scalar data-memory port.

---
 rtl/vlsu_sequencer_if.sv | 24 ++
 rtl/vlsu_sequencer.sv | 129 ++++++++++++
 tb/tb_vlsu_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/vlsu_sequencer_if.sv
// Scalar data-memory port driven by the vector load/store sequencer.
// Master issues single-element requests; slave grants and returns read data.
interface vlsu_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int SEW    = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [SEW-1:0]    mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [SEW-1:0]    mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/vlsu_sequencer.sv
// Breaks a unit-stride VLE32/VSE32 into VL single-element memory accesses.
// Loads gather into one vector register write; stores slice vs3 per element.
module vlsu_sequencer #(
  parameter int VL     = 8,
  parameter int SEW    = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        vd_i,
  input  logic [VL*SEW-1:0] st_data,
  output logic              stall,
  vlsu_sequencer_if.master  bus,
  output logic              vrf_we,
  output logic [4:0]        vrf_waddr,
  output logic [VL*SEW-1:0] vrf_wdata,
  output logic              done
);

  localparam int IDX_W = (VL > 1) ? $clog2(VL) : 1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(SEW / 8);
  localparam logic [IDX_W-1:0]  LAST   = IDX_W'(VL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RWAIT = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    idx_q;
  logic                store_q;
  logic [ADDR_W-1:0]   base_q;
  logic [4:0]          vd_q;
  logic [VL*SEW-1:0]   st_q;
  logic [VL*SEW-1:0]   ld_q;
  logic                last;

  assign last = (idx_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      store_q <= 1'b0;
      base_q  <= '0;
      vd_q    <= '0;
      st_q    <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            store_q <= is_store;
            base_q  <= base_addr;
            vd_q    <= vd_i;
            st_q    <= st_data;
            idx_q   <= '0;
            if (!is_store) ld_q <= '0;
          end
        end
        REQ: begin
          if (bus.mem_gnt && store_q && !last)
            idx_q <= idx_q + 1'b1;
        end
        RWAIT: begin
          if (bus.mem_rvalid) begin
            ld_q[idx_q*SEW +: SEW] <= bus.mem_rdata;
            if (!last) idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = REQ;
      REQ: begin
        if (bus.mem_gnt) begin
          if (!store_q)  state_d = RWAIT;
          else if (last) state_d = IDLE;
        end
      end
      RWAIT: if (bus.mem_rvalid) state_d = last ? WB : REQ;
      WB:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and data are pure functions of registered state, so they
  // stay stable for as long as the grant is withheld.
  always_comb begin
    stall         = (state_q != IDLE);
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    vrf_we        = 1'b0;
    vrf_waddr     = '0;
    done          = 1'b0;
    unique case (state_q)
      REQ: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = store_q;
        bus.mem_addr  = base_q + ADDR_W'(idx_q) * STRIDE;
        bus.mem_wdata = st_q[idx_q*SEW +: SEW];
        done          = store_q && bus.mem_gnt && last;
      end
      WB: begin
        vrf_we    = 1'b1;
        vrf_waddr = vd_q;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign vrf_wdata = ld_q;

endmodule

// File: tb/tb_vlsu_sequencer.sv
// Scoreboard bench for vlsu_sequencer: directed store/load sequences.
// A negedge monitor pops expected memory accesses and register writes.
module tb_vlsu_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_store;
  logic [31:0]  base_addr;
  logic [4:0]   vd_i;
  logic [255:0] st_data;
  logic         stall;
  logic         vrf_we;
  logic [4:0]   vrf_waddr;
  logic [255:0] vrf_wdata;
  logic         done;

  logic         gnt;
  logic         spur;
  logic         rv_q;
  logic [31:0]  rd_q;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [4:0]   r;
    logic [255:0] d;
  } vw_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  vw_t         vq[$];

  vlsu_sequencer_if mif ();

  vlsu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .vd_i      (vd_i),
    .st_data   (st_data),
    .stall     (stall),
    .bus       (mif),
    .vrf_we    (vrf_we),
    .vrf_waddr (vrf_waddr),
    .vrf_wdata (vrf_wdata),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Memory responder: read data is addr>>2, returned one cycle after grant.
  always @(posedge clk) begin
    rv_q <= mif.mem_req & mif.mem_gnt & ~mif.mem_we & ~rst;
    rd_q <= mif.mem_addr >> 2;
  end

  assign mif.mem_gnt    = gnt;
  assign mif.mem_rvalid = rv_q | spur;
  assign mif.mem_rdata  = spur ? 32'hDEADBEEF : rd_q;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mif.mem_req && mif.mem_gnt) begin
        if (mif.mem_we) begin
          if (wq.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_addr", mif.mem_addr, w.a);
            chk("wr_data", mif.mem_wdata, w.d);
          end
        end else begin
          if (rq.size() == 0) begin
            chk("unexpected_read", 1, 0);
          end else begin
            logic [31:0] a;
            a = rq.pop_front();
            chk("rd_addr", mif.mem_addr, a);
          end
        end
      end
      if (vrf_we) begin
        if (vq.size() == 0) begin
          chk("unexpected_vrf_we", 1, 0);
        end else begin
          vw_t v;
          v = vq.pop_front();
          chk("vrf_waddr", vrf_waddr, v.r);
          chk("vrf_wdata", vrf_wdata, v.d);
        end
      end
    end
  end

  // One operation from start (cycle 0) to two cycles past exp_end.
  // glo_*: grant low window; busy_n/spur_n/rst_cyc: disturbance cycles (0=none).
  task automatic run_op(input bit st, input logic [31:0] base,
                        input logic [4:0] vd, input logic [255:0] data,
                        input int glo_from, input int glo_to,
                        input int hold_e, input int busy_n,
                        input int spur_n, input int rst_cyc,
                        input int exp_end);
    int nrd;
    if (st) begin
      for (int i = 0; i < 8; i++) begin
        wr_t w;
        w.a = base + 32'(4 * i);
        w.d = data[i*32 +: 32];
        wq.push_back(w);
      end
    end else begin
      vw_t v;
      nrd = (rst_cyc != 0) ? rst_cyc / 2 : 8;
      for (int i = 0; i < nrd; i++) rq.push_back(base + 32'(4 * i));
      v.r = vd;
      v.d = '0;
      for (int i = 0; i < 8; i++) v.d[i*32 +: 32] = (base + 32'(4 * i)) >> 2;
      if (rst_cyc == 0) vq.push_back(v);
    end
    @(posedge clk);
    #1;
    start     = 1'b1;
    is_store  = st;
    base_addr = base;
    vd_i      = vd;
    st_data   = data;
    gnt       = 1'b1;
    for (int n = 1; n <= exp_end + 2; n++) begin
      @(posedge clk);
      #1;
      start = (n == busy_n);
      if (start) begin
        is_store  = ~st;
        base_addr = 32'hDEAD0000;
        vd_i      = 5'd31;
        st_data   = ~data;
      end
      gnt  = !(n >= glo_from && n <= glo_to);
      spur = (n == spur_n);
      rst  = (n == rst_cyc);
      @(negedge clk);
      chk($sformatf("stall_c%0d", n), stall, n <= exp_end);
      chk($sformatf("done_c%0d", n), done, rst_cyc == 0 && n == exp_end);
      chk($sformatf("vrf_we_c%0d", n), vrf_we,
          !st && rst_cyc == 0 && n == exp_end);
      if (!gnt) begin
        chk($sformatf("hold_req_c%0d", n), mif.mem_req, 1);
        chk($sformatf("hold_addr_c%0d", n), mif.mem_addr,
            base + 32'(4 * hold_e));
        chk($sformatf("hold_wdata_c%0d", n), mif.mem_wdata,
            data[hold_e*32 +: 32]);
      end
    end
    start = 1'b0;
    spur  = 1'b0;
    rst   = 1'b0;
    gnt   = 1'b1;
  endtask

  logic [255:0] d1;
  logic [255:0] d4;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    is_store  = 1'b0;
    base_addr = '0;
    vd_i      = '0;
    st_data   = '0;
    gnt       = 1'b1;
    spur      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d1[i*32 +: 32] = 32'(i + 1);
      d4[i*32 +: 32] = 32'hA0 + 32'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mif.mem_req, 0);
    chk("rst_mem_we", mif.mem_we, 0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    chk("rst_mem_wdata", mif.mem_wdata, 0);
    chk("rst_vrf_we", vrf_we, 0);
    chk("rst_vrf_waddr", vrf_waddr, 0);
    chk("rst_vrf_wdata", vrf_wdata, 0);
    chk("rst_done", done, 0);

    // store, clean: done cycle 8
    run_op(1, 32'h100, 5'd0, d1, 0, 0, 0, 0, 0, 0, 8);
    // load, clean: write-back cycle 17
    run_op(0, 32'h200, 5'd3, '0, 0, 0, 0, 0, 0, 0, 17);
    chk("vrf_hold", vrf_wdata[7*32 +: 32], 32'h87);
    // store, grant withheld on element 2 for 3 cycles
    run_op(1, 32'h100, 5'd0, d1, 3, 5, 2, 0, 0, 0, 11);
    // store, address wrap-around
    run_op(1, 32'hFFFFFFF8, 5'd0, d4, 0, 0, 0, 0, 0, 0, 8);
    // load, reset during RWAIT of element 4 (cycle 10)
    run_op(0, 32'h200, 5'd5, '0, 0, 0, 0, 0, 0, 10, 10);
    chk("post_rst_vrf_wdata", vrf_wdata, 0);
    // follow-on load after the aborted one
    run_op(0, 32'h300, 5'd7, '0, 0, 0, 0, 0, 0, 0, 17);
    // store with a start pulse while busy
    run_op(1, 32'h100, 5'd0, d1, 0, 0, 0, 4, 0, 0, 8);
    // load with busy start and a spurious rvalid in REQ
    run_op(0, 32'h200, 5'd3, '0, 0, 0, 0, 5, 3, 0, 17);

    chk("wq_empty", 256'(wq.size()), 0);
    chk("rq_empty", 256'(rq.size()), 0);
    chk("vq_empty", 256'(vq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
